// File: rtl/ps2_entry_if.sv
// ps2_entry_if: key-stream input, live accumulator view and committed-value slot of ps2_entry_ctrl
interface ps2_entry_if #(parameter int DIGITS = 4);
  logic [3:0] digit_i;
  logic new_data_i;
  logic ready_i;
  logic [4*DIGITS-1:0] acc_o;
  logic [4*DIGITS-1:0] data_o;
  logic [3:0] count_o;
  logic valid_o;
  logic overflow_o;
  logic drop_o;
  logic timeout_o;
  modport slave(
    input digit_i, new_data_i, ready_i,
    output acc_o, count_o, data_o, valid_o, overflow_o, drop_o, timeout_o
  );
  modport master(
    output digit_i, new_data_i, ready_i,
    input acc_o, count_o, data_o, valid_o, overflow_o, drop_o, timeout_o
  );
endinterface

// File: rtl/ps2_entry_ctrl.sv
// ps2_entry_ctrl: turns decoded PS/2 key codes into committed BCD numbers with backspace/clear/enter and idle timeout
module ps2_entry_ctrl #(
  parameter int DIGITS = 4,
  parameter int TIMEOUT_CYC = 1000000
) (
  input logic clk_i,
  input logic rst_i,
  ps2_entry_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int TW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] LIM = TW'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  localparam logic [TW-1:0] SAT = {TW{1'b1}};
  typedef enum logic {EMPTY, ENTRY} state_t;
  state_t state_q;
  logic [W-1:0] acc_q, data_q;
  logic [3:0] cnt_q;
  logic valid_q, ovf_q, drop_q, to_q;
  logic [TW-1:0] idle_q;
  logic key, expire;
  logic [W+3:0] acc_sh;
  assign key = bus.new_data_i && bus.digit_i <= 4'hC;
  assign expire = TIMEOUT_CYC > 0 && state_q == ENTRY && idle_q == LIM && !key;
  assign acc_sh = {acc_q, bus.digit_i};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      acc_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
      to_q <= 1'b0;
      idle_q <= '0;
    end else begin
      ovf_q <= 1'b0;
      drop_q <= 1'b0;
      to_q <= 1'b0;
      idle_q <= (state_q == EMPTY || key) ? '0 : idle_q + TW'(idle_q != SAT);
      if (valid_q && bus.ready_i) valid_q <= 1'b0;
      if (key && bus.digit_i <= 4'h9) begin
        if (cnt_q == 4'(DIGITS)) ovf_q <= 1'b1;
        else begin
          acc_q <= acc_sh[W-1:0];
          cnt_q <= cnt_q + 4'd1;
          state_q <= ENTRY;
        end
      end else if (key && bus.digit_i == 4'hA) begin
        if (cnt_q != '0) begin
          acc_q <= acc_q >> 4;
          cnt_q <= cnt_q - 4'd1;
          state_q <= cnt_q == 4'd1 ? EMPTY : ENTRY;
        end
      end else if ((key && bus.digit_i == 4'hC) || expire) begin
        acc_q <= '0;
        cnt_q <= '0;
        state_q <= EMPTY;
        to_q <= expire;
      end else if (key && bus.digit_i == 4'hB && cnt_q != '0) begin
        if (!valid_q || bus.ready_i) begin
          data_q <= acc_q;
          valid_q <= 1'b1;
          acc_q <= '0;
          cnt_q <= '0;
          state_q <= EMPTY;
        end else drop_q <= 1'b1;
      end
    end
  end
  assign bus.acc_o = acc_q;
  assign bus.count_o = cnt_q;
  assign bus.data_o = data_q;
  assign bus.valid_o = valid_q;
  assign bus.overflow_o = ovf_q;
  assign bus.drop_o = drop_q;
  assign bus.timeout_o = to_q;
endmodule

// File: tb/tb_ps2_entry_ctrl.sv
// tb_ps2_entry_ctrl: directed scenarios plus randomized key stream checked against a queue-based reference model
module tb_ps2_entry_ctrl;
  localparam int D = 4;
  localparam int T = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  ps2_entry_if #(.DIGITS(D)) bus();
  ps2_entry_ctrl #(.DIGITS(D), .TIMEOUT_CYC(T)) dut(.clk_i(clk), .rst_i(rst), .bus(bus));
  always #5 clk = ~clk;
  int q[$];
  logic mv;
  logic [15:0] md;
  logic movf, mdrop, mto;
  int cyc, last;
  function automatic logic [15:0] mval();
    logic [15:0] v = 16'h0;
    foreach (q[i]) v = (v << 4) | 16'(q[i]);
    return v;
  endfunction
  task automatic model_reset();
    q.delete();
    mv = 1'b0;
    md = 16'h0;
    movf = 1'b0;
    mdrop = 1'b0;
    mto = 1'b0;
    cyc = 0;
    last = 0;
  endtask
  task automatic step(input bit nd, input logic [3:0] dg, input bit rdy);
    logic pv;
    pv = mv;
    bus.new_data_i = nd;
    bus.digit_i = dg;
    bus.ready_i = rdy;
    cyc++;
    movf = 1'b0;
    mdrop = 1'b0;
    mto = 1'b0;
    if (mv && rdy) mv = 1'b0;
    if (nd && dg <= 4'd12) begin
      last = cyc;
      if (dg <= 4'd9) begin
        if (q.size() == D) movf = 1'b1;
        else q.push_back(int'(dg));
      end else if (dg == 4'd10) begin
        if (q.size() > 0) void'(q.pop_back());
      end else if (dg == 4'd12) q.delete();
      else if (q.size() > 0) begin
        if (!pv || rdy) begin
          md = mval();
          mv = 1'b1;
          q.delete();
        end else mdrop = 1'b1;
      end
    end else if (q.size() > 0 && cyc - last == T) begin
      q.delete();
      mto = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.new_data_i = 1'b0;
    bus.digit_i = 4'h0;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
  endtask
  task automatic test_reset();
    bus.new_data_i = 1'b0;
    bus.digit_i = 4'h0;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    #3;
    checks++; if (bus.acc_o !== 16'h0) begin failures++; $display("FAIL reset_acc got=%h exp=0000", bus.acc_o); end
    checks++; if (bus.count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.data_o !== 16'h0) begin failures++; $display("FAIL reset_data got=%h exp=0000", bus.data_o); end
    checks++; if ({bus.valid_o, bus.overflow_o, bus.drop_o, bus.timeout_o} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {bus.valid_o, bus.overflow_o, bus.drop_o, bus.timeout_o}); end
    do_reset();
  endtask
  task automatic test_entry();
    do_reset();
    step(1, 4'd1, 0); step(1, 4'd2, 0); step(1, 4'd3, 0);
    checks++; if (bus.acc_o !== 16'h0123) begin failures++; $display("FAIL entry_acc got=%h exp=0123", bus.acc_o); end
    checks++; if (bus.count_o !== 4'd3) begin failures++; $display("FAIL entry_count got=%0d exp=3", bus.count_o); end
    step(1, 4'hB, 0);
    checks++; if (bus.data_o !== 16'h0123) begin failures++; $display("FAIL enter_data got=%h exp=0123", bus.data_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL enter_valid got=%b exp=1", bus.valid_o); end
    checks++; if ({bus.acc_o, bus.count_o} !== 20'h0) begin failures++; $display("FAIL enter_cleared got=%h/%0d exp=0000/0", bus.acc_o, bus.count_o); end
    step(0, 4'd0, 0); step(0, 4'd0, 0);
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL valid_hold got=%b exp=1", bus.valid_o); end
    step(0, 4'd0, 1);
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL valid_fall got=%b exp=0", bus.valid_o); end
    checks++; if (bus.data_o !== 16'h0123) begin failures++; $display("FAIL data_hold got=%h exp=0123", bus.data_o); end
  endtask
  task automatic test_overflow_backspace();
    do_reset();
    step(1, 4'd9, 0); step(1, 4'd8, 0); step(1, 4'd7, 0); step(1, 4'd6, 0);
    checks++; if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.overflow_o); end
    step(1, 4'd5, 0);
    checks++; if (bus.acc_o !== 16'h9876) begin failures++; $display("FAIL ovf_acc got=%h exp=9876", bus.acc_o); end
    checks++; if (bus.count_o !== 4'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", bus.count_o); end
    checks++; if (bus.overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", bus.overflow_o); end
    step(1, 4'hA, 0);
    checks++; if (bus.overflow_o !== 1'b0) begin failures++; $display("FAIL ovf_len got=%b exp=0", bus.overflow_o); end
    step(1, 4'hA, 0);
    checks++; if (bus.acc_o !== 16'h0098) begin failures++; $display("FAIL bksp_acc got=%h exp=0098", bus.acc_o); end
    checks++; if (bus.count_o !== 4'd2) begin failures++; $display("FAIL bksp_count got=%0d exp=2", bus.count_o); end
    step(1, 4'hA, 0); step(1, 4'hA, 0); step(1, 4'hA, 0);
    checks++; if ({bus.acc_o, bus.count_o} !== 20'h0) begin failures++; $display("FAIL bksp_empty got=%h/%0d exp=0000/0", bus.acc_o, bus.count_o); end
  endtask
  task automatic test_drop();
    do_reset();
    step(1, 4'd1, 0); step(1, 4'hB, 0);
    step(1, 4'd4, 0); step(1, 4'hB, 0);
    checks++; if (bus.drop_o !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%b exp=1", bus.drop_o); end
    checks++; if (bus.acc_o !== 16'h0004) begin failures++; $display("FAIL drop_acc got=%h exp=0004", bus.acc_o); end
    checks++; if (bus.data_o !== 16'h0001) begin failures++; $display("FAIL drop_data got=%h exp=0001", bus.data_o); end
    step(1, 4'hB, 1);
    checks++; if (bus.drop_o !== 1'b0) begin failures++; $display("FAIL drop_len got=%b exp=0", bus.drop_o); end
    checks++; if (bus.data_o !== 16'h0004) begin failures++; $display("FAIL b2b_data got=%h exp=0004", bus.data_o); end
    checks++; if (bus.valid_o !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", bus.valid_o); end
    step(0, 4'd0, 1);
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL b2b_fall got=%b exp=0", bus.valid_o); end
  endtask
  task automatic test_timeout();
    do_reset();
    step(1, 4'd5, 0);
    repeat (15) step(0, 4'd0, 0);
    checks++; if (bus.timeout_o !== 1'b0) begin failures++; $display("FAIL to_early got=%b exp=0", bus.timeout_o); end
    checks++; if (bus.count_o !== 4'd1) begin failures++; $display("FAIL to_early_count got=%0d exp=1", bus.count_o); end
    step(0, 4'd0, 0);
    checks++; if (bus.timeout_o !== 1'b1) begin failures++; $display("FAIL to_pulse got=%b exp=1", bus.timeout_o); end
    checks++; if ({bus.acc_o, bus.count_o} !== 20'h0) begin failures++; $display("FAIL to_clear got=%h/%0d exp=0000/0", bus.acc_o, bus.count_o); end
    step(0, 4'd0, 0);
    checks++; if (bus.timeout_o !== 1'b0) begin failures++; $display("FAIL to_len got=%b exp=0", bus.timeout_o); end
    step(1, 4'd5, 0);
    repeat (15) step(0, 4'd0, 0);
    step(1, 4'd6, 0);
    checks++; if ({bus.timeout_o, bus.count_o} !== 5'd2) begin failures++; $display("FAIL to_saved got=%b/%0d exp=0/2", bus.timeout_o, bus.count_o); end
    step(1, 4'hC, 0);
    step(1, 4'd5, 0);
    for (int k = 0; k < 15; k++) step(1, 4'(13 + k % 3), 0);
    step(1, 4'hF, 0);
    checks++; if ({bus.timeout_o, bus.count_o} !== 5'h10) begin failures++; $display("FAIL to_ignored_codes got=%b/%0d exp=1/0", bus.timeout_o, bus.count_o); end
  endtask
  task automatic test_clear();
    do_reset();
    step(1, 4'd7, 0); step(1, 4'hC, 0);
    checks++; if ({bus.acc_o, bus.count_o} !== 20'h0) begin failures++; $display("FAIL clear got=%h/%0d exp=0000/0", bus.acc_o, bus.count_o); end
    step(1, 4'hB, 0);
    checks++; if (bus.valid_o !== 1'b0) begin failures++; $display("FAIL enter_empty got=%b exp=0", bus.valid_o); end
  endtask
  task automatic test_async_reset();
    do_reset();
    step(1, 4'd1, 0); step(1, 4'hB, 0); step(1, 4'd2, 0); step(1, 4'd3, 0);
    bus.new_data_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({bus.acc_o, bus.count_o, bus.data_o, bus.valid_o} !== 37'h0) begin
      failures++; $display("FAIL async_rst got=%h/%0d/%h/%b exp=0", bus.acc_o, bus.count_o, bus.data_o, bus.valid_o); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    step(1, 4'd3, 0);
    checks++; if (bus.acc_o !== 16'h0003) begin failures++; $display("FAIL post_rst_key got=%h exp=0003", bus.acc_o); end
  endtask
  task automatic test_random();
    logic [39:0] got, exp;
    bit nd;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      nd = ((i % 150) < 120) && ($urandom_range(0, 2) == 0);
      step(nd, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
      got = {bus.acc_o, bus.count_o, bus.data_o, bus.valid_o, bus.overflow_o, bus.drop_o, bus.timeout_o};
      exp = {mval(), 4'(q.size()), md, mv, movf, mdrop, mto};
      checks++;
      if (got !== exp) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp); end
    end
  endtask
  initial begin
    model_reset();
    test_reset();
    test_entry();
    test_overflow_backspace();
    test_drop();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_entry_ctrl.md
# ps2_entry_ctrl

Sequencer that sits directly behind the PS/2 receiver and turns its stream of decoded key codes into committed multi-digit numbers. It accumulates digits in a BCD shift register, applies backspace, clear and enter, and discards stale partial entries after an inactivity timeout. Committed values go to downstream logic through a one-entry valid/ready output slot.

## Interface
- DIGITS, 4: maximum digits per entry (1..8).
- TIMEOUT_CYC, 1000000: idle clock cycles before a partial entry is discarded; 0 disables the timeout.
- clk_i  in  1  system clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous and active-high.
- digit_i  in  4  key code from the PS/2 receiver: 0-9 digit, 4'hA backspace, 4'hB enter, 4'hC clear, 4'hD-4'hF ignored.
- new_data_i  in  1  one-cycle strobe; digit_i is valid when this is high.
- acc_o  out  4*DIGITS  live accumulator for display, most recent digit in [3:0].
- count_o  out  4  number of digits currently in acc_o (0..DIGITS).
- data_o  out  4*DIGITS  committed value; stable while valid_o=1.
- valid_o  out  1  committed value available.
- ready_i  in  1  downstream accepts; a transfer happens when valid_o&&ready_i.
- overflow_o  out  1  one-cycle pulse: a digit was rejected because count_o==DIGITS.
- drop_o  out  1  one-cycle pulse: an enter was rejected because the output slot was busy.
- timeout_o  out  1  one-cycle pulse: a partial entry was discarded.

## Operation
- Reset, asynchronous: acc_o=0, count_o=0, data_o=0, valid_o=0, all pulses 0, idle counter=0, FSM in EMPTY.
- FSM states:
  - EMPTY: count_o==0.
  - ENTRY: count_o>0.
  - The output slot (valid_o) is tracked independently of the FSM.
- Key actions, applied only on cycles where new_data_i=1:
  - Digit, count<DIGITS: acc <= {acc[4*DIGITS-5:0], digit_i}, count+1, EMPTY->ENTRY.
  - Digit, count==DIGITS: acc and count unchanged; overflow_o pulses.
  - Backspace: acc <= acc>>4, count-1. At count 0 it is a no-op. count reaching 0 -> EMPTY.
  - Clear: acc=0, count=0 -> EMPTY. No pulse.
  - Enter, count==0: ignored.
  - Enter, count>0, slot free or freeing this cycle (valid_o=0 or ready_i=1): data_o<=acc, valid_o<=1, acc<=0, count<=0 -> EMPTY.
  - Enter, count>0, slot busy (valid_o=1 and ready_i=0): entry stays intact; drop_o pulses.
  - Codes D-F: no effect. They do not reset the idle counter.
- Output slot:
  - valid_o falls the cycle after valid_o&&ready_i, unless a commit occurs in that same cycle, in which case valid_o stays 1 with the new data_o.
  - data_o holds its last value after the transfer.
- Timeout (TIMEOUT_CYC>0):
  - The idle counter increments each cycle in ENTRY.
  - It clears on any accepted key (0-C) and whenever the FSM is in EMPTY.
  - When the counter reaches TIMEOUT_CYC-1 with no key that cycle, the next edge sets acc=0, count=0 -> EMPTY, and timeout_o pulses.
  - A key arriving on the expiry cycle wins; no timeout occurs.
- Counter width is $clog2(TIMEOUT_CYC+1); it saturates and never wraps.

## Timing
- All outputs are registered.
- A strobe at edge n is visible on acc_o, count_o, data_o, valid_o and the pulses after edge n.
- Pulses last exactly one cycle.
- Back-to-back strobes on consecutive cycles are each processed. No strobe is lost except by the documented reject rules.
- ready_i is sampled only while valid_o=1.
- Reset asserted mid-entry or with valid_o=1 discards everything immediately, without waiting for a clock edge. The first key after reset release is processed normally.

## Test plan
- DIGITS=4: keys 1,2,3, enter with ready_i=0 -> acc_o shows 16'h0123, count_o=3. After enter: data_o=16'h0123, valid_o=1, acc_o=0, count_o=0. valid_o holds until ready_i=1, then falls the next cycle.
- Keys 9,8,7,6,5 -> acc_o=16'h9876, count_o=4, overflow_o pulses once on the 5. Then backspace twice -> acc_o=16'h0098, count_o=2. Backspace at count 0 -> no change.
- With valid_o=1 and ready_i=0: keys 4, enter -> drop_o pulses, acc_o=16'h0004 retained. Then enter with ready_i=1 on the same cycle -> data_o=16'h0004, valid_o stays 1.
- TIMEOUT_CYC=16: key 5, then idle -> timeout_o pulses 16 cycles after the strobe edge, count_o=0. A key on cycle 15 prevents the timeout. Codes D-F do not prevent it.
- Keys 7, clear, enter -> acc_o=0, enter ignored, valid_o stays 0.
- rst_i pulsed mid-clock with count_o=2 and valid_o=1 -> all outputs 0 before the next edge. Key 3 afterwards -> acc_o=16'h0003.
